regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources. Source A is the in-order pipeline writeback and has priority. Source B is a long-latency unit (mul/div, load-miss return) whose results wait in a small FIFO. The block sits directly in front of the register file: it drives `write_enable`, `rd` and `rd_din`, and exports a pending-destination mask so the hazard unit can stall readers and writers of in-flight registers.

---
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the in-order
// pipeline writeback (A, priority) and a FIFO of long-latency results (B).
// B is forced through after STARVE_LIMIT consecutive lost arbitration cycles.
// Optional macro WB_ARB_STATS_EN enables the A-side stall cycle counter.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        rf_write_enable,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_rd_din,
    output logic [31:0] pending_mask,
    output logic [31:0] stall_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [StW-1:0]  StLimC  = StW'(STARVE_LIMIT);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [StW-1:0]  starve_q;

    logic        empty, force_b, grant_a, grant_b, enq, deq;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Arbitration and handshakes; everything is suppressed while reset is high.
    always_comb begin
        empty     = (count_q == '0);
        force_b   = (starve_q >= StLimC) && !empty;
        grant_b   = !reset && !empty && (!a_valid || force_b);
        grant_a   = !reset && a_valid && !force_b;
        a_ready   = !reset && !force_b;
        b_ready   = !reset && (count_q < DepthC);
        enq       = b_valid && b_ready;
        deq       = grant_b;
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
    end

    // Write-port mux; writes to x0 are consumed without asserting write_enable.
    always_comb begin
        rf_write_enable = 1'b0;
        rf_rd           = '0;
        rf_rd_din       = '0;
        if (grant_b) begin
            rf_rd           = head_rd;
            rf_rd_din       = head_data;
            rf_write_enable = (head_rd != 5'd0);
        end else if (grant_a) begin
            rf_rd           = a_rd;
            rf_rd_din       = a_data;
            rf_write_enable = (a_rd != 5'd0);
        end
    end

    // Pending-destination mask over live FIFO entries, x0 never reported.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                pending_mask[fifo_rd_q[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    // FIFO storage; entries are only meaningful while their valid bit is set.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q]   <= b_rd;
            fifo_data_q[wr_ptr_q] <= b_data;
        end
    end

    // FIFO pointers, occupancy and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            starve_q <= '0;
        end else begin
            if (enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (empty || deq) begin
                starve_q <= '0;
            end else if (starve_q < StLimC) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [31:0] stall_q;

    // Counts cycles where the pipeline writeback was held off by a forced B grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (a_valid && !a_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        a_ready, b_ready, rf_write_enable;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_din, pending_mask, stall_count;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk             (clk),
        .reset           (reset),
        .a_valid         (a_valid),
        .a_rd            (a_rd),
        .a_data          (a_data),
        .a_ready         (a_ready),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_rd            (b_rd),
        .b_data          (b_data),
        .rf_write_enable (rf_write_enable),
        .rf_rd           (rf_rd),
        .rf_rd_din       (rf_rd_din),
        .pending_mask    (pending_mask),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] din;
        logic        ar;
        logic        br;
        logic [31:0] mask;
        logic [31:0] stall;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    exp_t        q_exp[$];
    ent_t        mq[$];
    int          starve = 0;
    logic [31:0] stall_m = '0;
    int          n_total = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, predict outputs from the model, advance the model.
    task automatic step(input logic rst, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic bv, input logic [4:0] brd,
                        input logic [31:0] bd, output logic acc);
        exp_t e;
        ent_t n;
        logic emp, frc, gb, ga;
        @(posedge clk);
        #1;
        reset = rst; a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        e.mask = '0;
        foreach (mq[i]) if (mq[i].rd != 0) e.mask[mq[i].rd] = 1'b1;
`ifdef WB_ARB_STATS_EN
        e.stall = stall_m;
`else
        e.stall = 32'h0;
`endif
        e.rst = rst;
        e.we = 1'b0; e.rd = '0; e.din = '0;
        acc = 1'b0;
        if (rst) begin
            e.ar = 1'b0;
            e.br = 1'b0;
            mq.delete();
            starve = 0;
            stall_m = '0;
        end else begin
            emp  = (mq.size() == 0);
            frc  = (starve >= LIM) && !emp;
            gb   = !emp && (!av || frc);
            ga   = av && !frc;
            e.ar = !frc;
            e.br = (mq.size() < DEPTH);
            if (gb) begin
                e.rd = mq[0].rd; e.din = mq[0].data; e.we = (mq[0].rd != 0);
            end else if (ga) begin
                e.rd = ard; e.din = ad; e.we = (ard != 0);
            end
            if (av && frc) stall_m++;
            if (emp || gb) starve = 0;
            else if (starve < LIM) starve++;
            if (gb) void'(mq.pop_front());
            if (bv && e.br) begin
                n.rd = brd; n.data = bd;
                mq.push_back(n);
                acc = 1'b1;
            end
        end
        q_exp.push_back(e);
    endtask

    exp_t me;

    // Monitor: compare every predicted cycle against the DUT away from the edge.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            me = q_exp.pop_front();
            check("write_enable", {31'h0, rf_write_enable}, {31'h0, me.we});
            check("a_ready", {31'h0, a_ready}, {31'h0, me.ar});
            check("b_ready", {31'h0, b_ready}, {31'h0, me.br});
            check("pending_mask", pending_mask, me.mask);
            check("stall_count", stall_count, me.stall);
            if (!me.rst) begin
                check("rf_rd", {27'h0, rf_rd}, {27'h0, me.rd});
                check("rf_rd_din", rf_rd_din, me.din);
            end
        end
    end

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
    endtask

    task automatic a_only(input int n, input logic [4:0] rd, input logic [31:0] d);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, rd, d + 32'(i), 1'b0, 5'd0, 32'h0, acc);
    endtask

    initial begin
        logic acc;
        logic av, bv, rst;
        // Reset
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        idle(1);
        // A only
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, acc);
        idle(1);
        // B only
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE, acc);
        idle(3);
        // Starvation: one B entry, A held high
        step(1'b0, 1'b1, 5'd9, 32'h100, 1'b1, 5'd3, 32'hBEEF, acc);
        a_only(7, 5'd9, 32'h200);
        idle(1);
        // Full FIFO with A busy; the third offer is held until accepted
        step(1'b0, 1'b1, 5'd10, 32'h300, 1'b1, 5'd11, 32'h11, acc);
        step(1'b0, 1'b1, 5'd10, 32'h301, 1'b1, 5'd12, 32'h22, acc);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 5'd10, 32'h302, 1'b1, 5'd13, 32'h33, acc);
            if (acc) break;
        end
        a_only(12, 5'd10, 32'h400);
        idle(2);
        // x0 on both sides
        step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hF00D, acc);
        idle(3);
        // Mid-operation reset with two entries queued and starve at 3
        step(1'b0, 1'b1, 5'd4, 32'h500, 1'b1, 5'd20, 32'hA1, acc);
        step(1'b0, 1'b1, 5'd4, 32'h501, 1'b1, 5'd21, 32'hA2, acc);
        a_only(2, 5'd4, 32'h502);
        step(1'b1, 1'b1, 5'd4, 32'h600, 1'b0, 5'd0, 32'h0, acc);
        step(1'b0, 1'b1, 5'd6, 32'h700, 1'b1, 5'd22, 32'hA3, acc);
        a_only(7, 5'd6, 32'h800);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            av  = ($urandom_range(0, 99) < 65);
            bv  = ($urandom_range(0, 99) < 45);
            step(rst, av, 5'($urandom_range(0, 31)), $urandom, bv,
                 5'($urandom_range(0, 31)), $urandom, acc);
        end
        idle(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(q_exp.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
